// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 raster constants plus the counter and colour widths.
//   vga_sync and the pattern stages downstream import this package so every
//   stage agrees on where the active window sits.
//
//   Contents:
//     CNT_W / RGB_W      counter width (hc, vc) and per-pixel colour width
//     VGA_*              default horizontal/vertical timing for 640x480@60
//     cnt_t / rgb_t      convenience types for counters and colour words
//     in_span()          half-open window test lo <= v < hi
package vga_timing_pkg;

   localparam int CNT_W = 10;
   localparam int RGB_W = 6;

   localparam int VGA_HPIXELS = 800;
   localparam int VGA_VLINES  = 521;
   localparam int VGA_HPULSE  = 96;
   localparam int VGA_VPULSE  = 2;
   localparam int VGA_HBP     = 144;
   localparam int VGA_HFP     = 784;
   localparam int VGA_VBP     = 31;
   localparam int VGA_VFP     = 511;

   localparam int DIV_MAX = 16;
   localparam int DIV_W   = 4;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [RGB_W-1:0] rgb_t;

   function automatic logic in_span(input cnt_t v, input cnt_t lo, input cnt_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// pix_tick_gen
//   Pixel-rate divider. Counts 0..CLK_DIV-1 on every enabled clock and
//   raises tick_o (combinationally) on the clock where the count sits at
//   CLK_DIV-1; the count wraps to 0 on that same edge. With CLK_DIV=1 every
//   enabled clock is a tick. The count holds while en_i is low.
//
//   Ports:
//     clk     system clock
//     rst     asynchronous active-high reset
//     en_i    advance enable
//     tick_o  high on clocks where the raster counters should advance
module pix_tick_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             tick;

   assign tick   = en_i && (div_q == DIV_LAST);
   assign tick_o = tick;

   always_comb begin
      div_d = div_q;
      if (en_i) begin
         div_d = tick ? '0 : div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/vga_sync.sv
// vga_sync
//   VGA raster timing generator. Produces horizontal/vertical pixel counters,
//   active-low sync pulses, the active-video flag, a per-advance strobe, a
//   start-of-frame strobe and an 8-bit completed-frame counter.
//
//   Every output is a flop. The sync and window flags are computed from the
//   next-state counter values, so in any cycle they describe the hc/vc shown
//   in that same cycle and downstream decode needs no skew compensation.
//
//   Ports:
//     clk        system clock
//     rst        asynchronous active-high reset
//     en         counters/divider advance only while high
//     hc         horizontal counter, 0..HPIXELS-1
//     vc         vertical counter, 0..VLINES-1
//     hsync      active-low, low for hc < HPULSE
//     vsync      active-low, low for vc < VPULSE
//     video_on   high for HBP <= hc < HFP and VBP <= vc < VFP
//     pix_tick   high in the cycle after each counter advance
//     sof        one-clock strobe when hc/vc first read (0,0) after a wrap
//     frame_cnt  frames completed, wraps 255 -> 0
module vga_sync
   import vga_timing_pkg::*;
#(
   parameter int HPIXELS = VGA_HPIXELS,
   parameter int VLINES  = VGA_VLINES,
   parameter int HPULSE  = VGA_HPULSE,
   parameter int VPULSE  = VGA_VPULSE,
   parameter int HBP     = VGA_HBP,
   parameter int HFP     = VGA_HFP,
   parameter int VBP     = VGA_VBP,
   parameter int VFP     = VGA_VFP,
   parameter int CLK_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] hc,
   output logic [CNT_W-1:0] vc,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic             pix_tick,
   output logic             sof,
   output logic [7:0]       frame_cnt
);

   localparam cnt_t H_LAST   = cnt_t'(HPIXELS - 1);
   localparam cnt_t V_LAST   = cnt_t'(VLINES - 1);
   localparam cnt_t H_PULSE  = cnt_t'(HPULSE);
   localparam cnt_t V_PULSE  = cnt_t'(VPULSE);
   localparam cnt_t H_BP     = cnt_t'(HBP);
   localparam cnt_t H_FP     = cnt_t'(HFP);
   localparam cnt_t V_BP     = cnt_t'(VBP);
   localparam cnt_t V_FP     = cnt_t'(VFP);

   logic tick;

   cnt_t       hc_q, hc_d;
   cnt_t       vc_q, vc_d;
   logic [7:0] frame_q, frame_d;
   logic       frame_wrap;
   logic       hsync_q, vsync_q, video_q;
   logic       pix_tick_q, sof_q;

   pix_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .tick_o (tick)
   );

   always_comb begin
      hc_d       = hc_q;
      vc_d       = vc_q;
      frame_d    = frame_q;
      frame_wrap = 1'b0;
      if (tick) begin
         if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
               vc_d       = '0;
               frame_d    = frame_q + 8'd1;
               frame_wrap = 1'b1;
            end else begin
               vc_d = vc_q + cnt_t'(1);
            end
         end else begin
            hc_d = hc_q + cnt_t'(1);
         end
      end
   end

   // Flags are evaluated on the next-state counters every clock, including
   // when en is low (hc_d == hc_q then), so they never disagree with hc/vc.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc_q       <= '0;
         vc_q       <= '0;
         frame_q    <= '0;
         hsync_q    <= 1'b0;
         vsync_q    <= 1'b0;
         video_q    <= 1'b0;
         pix_tick_q <= 1'b0;
         sof_q      <= 1'b0;
      end else begin
         hc_q       <= hc_d;
         vc_q       <= vc_d;
         frame_q    <= frame_d;
         hsync_q    <= (hc_d >= H_PULSE);
         vsync_q    <= (vc_d >= V_PULSE);
         video_q    <= in_span(hc_d, H_BP, H_FP) && in_span(vc_d, V_BP, V_FP);
         pix_tick_q <= tick;
         sof_q      <= frame_wrap;
      end
   end

   assign hc        = hc_q;
   assign vc        = vc_q;
   assign frame_cnt = frame_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign video_on  = video_q;
   assign pix_tick  = pix_tick_q;
   assign sof       = sof_q;

endmodule
